tt_um_monobit: RTL and testbench

// - NIST SP800-22 frequency (monobit) test engine in Tiny Tapeout user-project wrapper form.
// - Consumes a serial bit stream in fixed blocks of N_BITS and forms S = (#ones - #zeros).
// - At block end, flags the block as random when |S| <= THRESHOLD (alpha = 0.01; 29 ~= 2.576*sqrt(128)).
// - Exposes |S| on the bidirectional pins, which are always driven as outputs.

---
 rtl/monobit_pkg.sv | 31 +++
 rtl/monobit_core.sv | 92 +++++++++
 rtl/tt_um_monobit.sv | 38 +++
 tb/tb_tt_um_monobit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/monobit_pkg.sv
// Shared constants and helpers for the monobit (NIST SP800-22 frequency) test engine.
package monobit_pkg;

    localparam int N_BITS    = 128;
    localparam int THRESHOLD = 29;

    // Sum spans -N_BITS..+N_BITS; the count must reach N_BITS itself.
    localparam int SUM_W = $clog2(N_BITS) + 2;
    localparam int CNT_W = $clog2(N_BITS + 1);

    localparam int DATA_BIT  = 0;
    localparam int VALID_BIT = 1;
    localparam int CLEAR_BIT = 2;

    function automatic int abs_mag(input logic signed [SUM_W-1:0] s);
        int v;
        v = int'(s);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [7:0] sat8(input int m);
        logic [31:0] mv;
        mv = 32'(m);
        if (m > 255) begin
            return 8'd255;
        end else begin
            return mv[7:0];
        end
    endfunction

endpackage

// File: rtl/monobit_core.sv
// Accumulates +1/-1 per accepted bit over a block of N_BITS and decides randomness at block end.
module monobit_core
    import monobit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clear,
    output logic       done,
    output logic       result_valid,
    output logic       is_random,
    output logic       busy,
    output logic [7:0] abs_sum
);

    logic signed [SUM_W-1:0] sum_q, sum_d, sum_step_s;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_step_s;
    logic [7:0]              abs_q, abs_d;
    logic                    rnd_q, rnd_d;
    logic                    rv_q, rv_d;
    logic                    done_q, done_d;
    logic                    busy_q;
    int                      mag_s;

    // Next-state: clear beats a simultaneous bit; the block-ending bit restarts counting at once.
    always_comb begin
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        abs_d      = abs_q;
        rnd_d      = rnd_q;
        rv_d       = rv_q;
        done_d     = 1'b0;
        sum_step_s = bit_in ? (sum_q + SUM_W'(1)) : (sum_q - SUM_W'(1));
        cnt_step_s = cnt_q + CNT_W'(1);
        mag_s      = abs_mag(sum_step_s);
        if (en) begin
            if (clear) begin
                sum_d = SUM_W'(0);
                cnt_d = CNT_W'(0);
                abs_d = 8'd0;
                rnd_d = 1'b0;
                rv_d  = 1'b0;
            end else if (bit_valid) begin
                if (cnt_step_s == CNT_W'(N_BITS)) begin
                    sum_d  = SUM_W'(0);
                    cnt_d  = CNT_W'(0);
                    abs_d  = sat8(mag_s);
                    rnd_d  = (mag_s <= THRESHOLD);
                    rv_d   = 1'b1;
                    done_d = 1'b1;
                end else begin
                    sum_d = sum_step_s;
                    cnt_d = cnt_step_s;
                end
            end else begin
                sum_d = sum_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= SUM_W'(0);
            cnt_q  <= CNT_W'(0);
            abs_q  <= 8'd0;
            rnd_q  <= 1'b0;
            rv_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            abs_q  <= abs_d;
            rnd_q  <= rnd_d;
            rv_q   <= rv_d;
            done_q <= done_d;
            busy_q <= (cnt_d != CNT_W'(0));
        end
    end

    assign done         = done_q;
    assign result_valid = rv_q;
    assign is_random    = rnd_q;
    assign busy         = busy_q;
    assign abs_sum      = abs_q;

endmodule

// File: rtl/tt_um_monobit.sv
// Tiny Tapeout wrapper for the monobit engine: pin mapping and tie-offs only.
module tt_um_monobit
    import monobit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic done_s, rv_s, rnd_s, busy_s;
    logic [7:0] abs_s;
    logic unused_s;

    monobit_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (ena),
        .bit_in       (ui_in[DATA_BIT]),
        .bit_valid    (ui_in[VALID_BIT]),
        .clear        (ui_in[CLEAR_BIT]),
        .done         (done_s),
        .result_valid (rv_s),
        .is_random    (rnd_s),
        .busy         (busy_s),
        .abs_sum      (abs_s)
    );

    assign uo_out   = {4'b0000, busy_s, rnd_s, rv_s, done_s};
    assign uio_out  = abs_s;
    assign uio_oe   = 8'hFF;
    assign unused_s = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_monobit.sv
// Randomized bench for tt_um_monobit against a block-level count-the-ones reference model.
module tb_tt_um_monobit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit   blk[$];
    int   m_abs = 0;
    bit   m_rnd = 1'b0;
    bit   m_rv = 1'b0;
    bit   m_done = 1'b0;
    bit   blk_src[$];

    tt_um_monobit dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_uo();
        logic busy;
        busy = (blk.size() != 0);
        return {4'b0000, busy, m_rnd, m_rv, m_done};
    endfunction

    function automatic logic [7:0] exp_abs();
        logic [31:0] a;
        a = (m_abs > 255) ? 32'd255 : 32'(m_abs);
        return a[7:0];
    endfunction

    // Block decision from the rules: S = ones - zeros over the whole block.
    task automatic model_edge(input bit en, input bit d, input bit v, input bit c);
        int ones;
        int s;
        m_done = 1'b0;
        if (en && c) begin
            blk.delete();
            m_abs = 0; m_rnd = 1'b0; m_rv = 1'b0;
        end else if (en && v) begin
            blk.push_back(d);
            if (blk.size() == 128) begin
                ones = 0;
                foreach (blk[i]) ones += int'(blk[i]);
                s = ones - (128 - ones);
                m_abs = (s < 0) ? -s : s;
                m_rnd = (m_abs <= 29);
                m_rv = 1'b1;
                m_done = 1'b1;
                blk.delete();
            end
        end
    endtask

    task automatic step(input bit en, input bit d, input bit v, input bit c);
        ena = en;
        ui_in = {5'b00000, c, v, d};
        @(posedge clk);
        model_edge(en, d, v, c);
        #1;
    endtask

    // Shuffled block with exactly k ones.
    task automatic make_block(input int k);
        int j;
        bit t;
        blk_src.delete();
        for (int i = 0; i < 128; i++) blk_src.push_back(i < k);
        for (int i = 127; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = blk_src[i]; blk_src[i] = blk_src[j]; blk_src[j] = t;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
            n_err++;
            $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h want 00 00 ff", uo_out, uio_out, uio_oe);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                n_err++;
                $display("FAIL all_ones[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
        n_vec++;
        if (uo_out !== 8'b0000_0011 || uio_out !== 8'd128) begin
            n_err++;
            $display("FAIL all_ones_final: uo=%h abs=%0d want uo=03 abs=128", uo_out, uio_out);
        end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 128; i++) begin
            step(1'b1, ((i % 2) == 0), 1'b1, 1'b0);
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                n_err++;
                $display("FAIL alternating[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
        n_vec++;
        if (uo_out !== 8'b0000_0111 || uio_out !== 8'd0) begin
            n_err++;
            $display("FAIL alternating_final: uo=%h abs=%0d want uo=07 abs=0", uo_out, uio_out);
        end
    endtask

    task automatic test_threshold();
        int kv[2] = '{78, 79};
        logic [7:0] want_uo[2] = '{8'h07, 8'h03};
        logic [7:0] want_abs[2] = '{8'd28, 8'd30};
        for (int t = 0; t < 2; t++) begin
            make_block(kv[t]);
            for (int i = 0; i < 128; i++) begin
                if ($urandom_range(3, 0) == 0) step(1'b1, 1'($urandom), 1'b0, 1'b0);
                step(1'b1, blk_src[i], 1'b1, 1'b0);
                n_vec++;
                if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                    n_err++;
                    $display("FAIL threshold_k%0d[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", kv[t], i, uo_out, uio_out, exp_uo(), exp_abs());
                end
            end
            n_vec++;
            if (uo_out !== want_uo[t] || uio_out !== want_abs[t]) begin
                n_err++;
                $display("FAIL threshold_final_k%0d: uo=%h abs=%0d want uo=%h abs=%0d", kv[t], uo_out, uio_out, want_uo[t], want_abs[t]);
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 60; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_err++;
            $display("FAIL clear: uo=%h abs=%0d want uo=00 abs=0", uo_out, uio_out);
        end
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                n_err++;
                $display("FAIL clear_zeros[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
        n_vec++;
        if (uo_out !== 8'h03 || uio_out !== 8'd128) begin
            n_err++;
            $display("FAIL clear_final: uo=%h abs=%0d want uo=03 abs=128", uo_out, uio_out);
        end
    endtask

    task automatic test_ena_gap();
        int done_cnt = 0;
        for (int i = 0; i < 138; i++) begin
            if (i >= 64 && i < 74) step(1'b0, 1'($urandom), 1'(i % 2), 1'($urandom));
            else step(1'b1, 1'b1, 1'b1, 1'b0);
            if (uo_out[0] === 1'b1) done_cnt++;
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs() || (uo_out[0] === 1'b1) != (i == 137)) begin
                n_err++;
                $display("FAIL ena_gap[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL ena_gap_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        blk.delete(); m_abs = 0; m_rnd = 1'b0; m_rv = 1'b0; m_done = 1'b0;
        #1;
        n_vec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
            n_err++;
            $display("FAIL async_reset: uo=%h uio_out=%h uio_oe=%h want 00 00 ff", uo_out, uio_out, uio_oe);
        end
        ui_in = 8'h00;
        #2 rst_n = 1'b1;
        make_block(90);
        for (int i = 0; i < 128; i++) begin
            step(1'b1, blk_src[i], 1'b1, 1'b0);
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                n_err++;
                $display("FAIL post_reset[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
        n_vec++;
        if (uo_out !== 8'h03 || uio_out !== 8'd52) begin
            n_err++;
            $display("FAIL post_reset_final: uo=%h abs=%0d want uo=03 abs=52", uo_out, uio_out);
        end
    endtask

    task automatic test_random();
        bit en, v, c;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(9, 0) != 0);
            v  = ($urandom_range(9, 0) < 8);
            c  = ($urandom_range(399, 0) == 0);
            step(en, 1'($urandom_range(99, 0) < 58), v, c);
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_abs()) begin
                n_err++;
                $display("FAIL random[%0d]: uo=%h abs=%0d want uo=%h abs=%0d", i, uo_out, uio_out, exp_uo(), exp_abs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_threshold();
        test_clear();
        test_ena_gap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
